pll_lock_rst_seq: RTL and testbench

Reset sequencer for the fabric CCC/PLL. It drives the PLL POWERDOWN_N input, consumes the asynchronous PLL LOCK output, and produces staggered, registered active-high resets for downstream fabric stages (core, memory, peripherals). It runs on the free-running CCC reference clock, so it keeps operating while the PLL is powered down or unlocked. It also re-sequences on lock loss or on a software request.

---
 rtl/pll_lock_rst_seq.sv | 178 +++++++++++++++++
 tb/tb_pll_lock_rst_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_rst_seq.sv
// Reset sequencer for the fabric CCC/PLL: power-down pulse, lock qualification with timeout,
// then staggered release of the per-stage resets. Runs on the free-running reference clock.
module pll_lock_rst_seq #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PD_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned NUM_STAGES         = 3,
  parameter int unsigned STAGE_GAP          = 16,
  parameter int unsigned CNT_W              = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PLL_LOCK,
  input  logic                  SW_RESET_REQ,
  output logic                  PLL_POWERDOWN_N,
  output logic [NUM_STAGES-1:0] RST_OUT,
  output logic                  READY,
  output logic [CNT_W-1:0]      LOCK_LOSS_CNT,
  output logic [CNT_W-1:0]      RETRY_CNT,
  output logic [1:0]            STATE
);

  localparam int unsigned PD_W  = $clog2(PD_CYCLES + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(STAGE_GAP + 1);

  localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(PD_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    StPwrdn    = 2'b00,
    StWaitLock = 2'b01,
    StRelease  = 2'b10,
    StRun      = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [PD_W-1:0]         pd_cnt_q, pd_cnt_d;
  logic [STB_W-1:0]        stable_q, stable_d;
  logic [TO_W-1:0]         timeout_q, timeout_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [NUM_STAGES-1:0]   rst_out_q, rst_out_d;
  logic                    ready_q, ready_d;
  logic                    pd_n_q, pd_n_d;
  logic [CNT_W-1:0]        loss_q, loss_d;
  logic [CNT_W-1:0]        retry_q, retry_d;

  logic lock_s;
  logic lock_drop;
  logic sw_abort;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign lock_drop = ((state_q == StRelease) || (state_q == StRun)) && !lock_s;
  assign sw_abort  = SW_RESET_REQ && (state_q != StPwrdn);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    pd_cnt_d  = pd_cnt_q;
    stable_d  = stable_q;
    timeout_d = timeout_q;
    gap_d     = gap_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    pd_n_d    = pd_n_q;
    loss_d    = loss_q;
    retry_d   = retry_q;

    // A lock drop is counted even when a simultaneous software request wins the transition.
    if (lock_drop) begin
      loss_d = sat_inc(loss_q);
    end

    if (sw_abort) begin
      state_d   = StPwrdn;
      pd_cnt_d  = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
      pd_n_d    = 1'b0;
    end else if (lock_drop) begin
      state_d   = StWaitLock;
      stable_d  = '0;
      timeout_d = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        StPwrdn: begin
          if (pd_cnt_q == PD_LAST) begin
            state_d   = StWaitLock;
            stable_d  = '0;
            timeout_d = '0;
            pd_n_d    = 1'b1;
          end else begin
            pd_cnt_d = pd_cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          timeout_d = timeout_q + 1'b1;
          stable_d  = lock_s ? stable_q + 1'b1 : '0;
          if (lock_s && (stable_q == STB_LAST)) begin
            state_d   = StRelease;
            gap_d     = '0;
            rst_out_d = {NUM_STAGES{1'b1}} << 1;
          end else if (timeout_q == TO_LAST) begin
            state_d  = StPwrdn;
            pd_cnt_d = '0;
            pd_n_d   = 1'b0;
            retry_d  = sat_inc(retry_q);
          end
        end
        StRelease: begin
          // Each gap period clears the next stage; one extra gap after the last enters RUN.
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (rst_out_q == '0) begin
              state_d = StRun;
              ready_d = 1'b1;
            end else begin
              rst_out_d = rst_out_q << 1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        StRun: begin
        end
        default: begin
          state_d = StPwrdn;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StPwrdn;
      sync_q    <= '0;
      pd_cnt_q  <= '0;
      stable_q  <= '0;
      timeout_q <= '0;
      gap_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      pd_n_q    <= 1'b0;
      loss_q    <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], PLL_LOCK};
      pd_cnt_q  <= pd_cnt_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
      gap_q     <= gap_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      pd_n_q    <= pd_n_d;
      loss_q    <= loss_d;
      retry_q   <= retry_d;
    end
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign RST_OUT         = rst_out_q;
  assign READY           = ready_q;
  assign LOCK_LOSS_CNT   = loss_q;
  assign RETRY_CNT       = retry_q;
  assign STATE           = state_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Bench for pll_lock_rst_seq: phase/elapsed-time reference model feeding a scoreboard queue,
// plus directed scenarios for bring-up, glitches, timeouts, lock loss, software and async reset.
module tb_pll_lock_rst_seq;

  localparam int S   = 2;
  localparam int PD  = 4;
  localparam int STB = 8;
  localparam int TO  = 64;
  localparam int N   = 3;
  localparam int G   = 2;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          PLL_LOCK = 1'b0;
  logic          SW_RESET_REQ = 1'b0;
  logic          PLL_POWERDOWN_N;
  logic [N-1:0]  RST_OUT;
  logic          READY;
  logic [CW-1:0] LOCK_LOSS_CNT;
  logic [CW-1:0] RETRY_CNT;
  logic [1:0]    STATE;

  int total = 0;
  int bad   = 0;

  pll_lock_rst_seq #(
    .SYNC_STAGES       (S),
    .PD_CYCLES         (PD),
    .LOCK_STABLE_CYCLES(STB),
    .LOCK_TIMEOUT      (TO),
    .NUM_STAGES        (N),
    .STAGE_GAP         (G),
    .CNT_W             (CW)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .PLL_LOCK       (PLL_LOCK),
    .SW_RESET_REQ   (SW_RESET_REQ),
    .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
    .RST_OUT        (RST_OUT),
    .READY          (READY),
    .LOCK_LOSS_CNT  (LOCK_LOSS_CNT),
    .RETRY_CNT      (RETRY_CNT),
    .STATE          (STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]    st;
    logic          pdn;
    logic [N-1:0]  rst;
    logic          rdy;
    logic [CW-1:0] loss;
    logic [CW-1:0] retry;
  } obs_t;

  obs_t exp_q[$];

  // Reference model: phase (0 PWRDN,1 WAIT,2 RELEASE,3 RUN) and cycles elapsed in it.
  int m_ph = 0, m_t = 0, m_stb = 0, m_loss = 0, m_retry = 0;
  bit hist[S];

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_stb = 0; m_loss = 0; m_retry = 0;
    for (int i = 0; i < S; i++) hist[i] = 1'b0;
  endtask

  task automatic model_step(input bit ls, input bit sw);
    bit rr;
    rr = (m_ph == 2) || (m_ph == 3);
    if (rr && !ls && m_loss < SAT) m_loss++;
    if (sw && m_ph != 0) begin
      m_ph = 0; m_t = 0;
    end else if (rr && !ls) begin
      m_ph = 1; m_t = 0; m_stb = 0;
    end else begin
      case (m_ph)
        0: if (m_t + 1 == PD) begin m_ph = 1; m_t = 0; m_stb = 0; end else m_t++;
        1: begin
          m_stb = ls ? m_stb + 1 : 0;
          if (m_stb == STB) begin
            m_ph = 2; m_t = 0;
          end else if (m_t + 1 == TO) begin
            m_ph = 0; m_t = 0;
            if (m_retry < SAT) m_retry++;
          end else m_t++;
        end
        2: if (m_t + 1 == N * G) begin m_ph = 3; m_t = 0; end else m_t++;
        default: ;
      endcase
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int clr;
    int all1;
    all1    = (1 << N) - 1;
    o.st    = m_ph[1:0];
    o.pdn   = (m_ph != 0);
    o.rdy   = (m_ph == 3);
    o.loss  = m_loss[CW-1:0];
    o.retry = m_retry[CW-1:0];
    if (m_ph == 3) o.rst = '0;
    else if (m_ph == 2) begin
      clr = m_t / G + 1;
      if (clr > N) clr = N;
      o.rst = N'(all1 & ~((1 << clr) - 1));
    end else o.rst = '1;
    return o;
  endfunction

  initial begin
    bit ls;
    model_reset();
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        model_reset();
        exp_q.delete();
      end else begin
        ls = hist[S-1];
        for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = PLL_LOCK;
        model_step(ls, SW_RESET_REQ);
        exp_q.push_back(model_out());
      end
    end
  end

  // Monitor: every cycle the DUT presents a registered output word, compare with the queue head.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge CLK);
      if (!RST && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {STATE, PLL_POWERDOWN_N, RST_OUT, READY, LOCK_LOSS_CNT, RETRY_CNT};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL scoreboard @%0t: got st=%0d pdn=%0d rst=%b rdy=%0d loss=%0d retry=%0d, expected st=%0d pdn=%0d rst=%b rdy=%0d loss=%0d retry=%0d",
                   $time, a.st, a.pdn, a.rst, a.rdy, a.loss, a.retry,
                   e.st, e.pdn, e.rst, e.rdy, e.loss, e.retry);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // sel: 0 STATE, 1 RST_OUT, 2 READY, 3 PLL_POWERDOWN_N, other RETRY_CNT
  task automatic wait_until(input int sel, input int val, input int budget, input string nm);
    int v;
    bit hit;
    hit = 1'b0;
    v   = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge CLK);
      #1;
      case (sel)
        0:       v = int'(STATE);
        1:       v = int'(RST_OUT);
        2:       v = int'(READY);
        3:       v = int'(PLL_POWERDOWN_N);
        default: v = int'(RETRY_CNT);
      endcase
      if (v == val) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: timed out, last=%0d wanted=%0d", nm, v, val);
    end
  endtask

  // Counts rising clock edges until PLL_POWERDOWN_N equals val (bounded).
  task automatic edges_until_pdn(input bit val, output int n);
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (PLL_POWERDOWN_N !== val && n < 200);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    PLL_LOCK = 1'b0;
    SW_RESET_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, int'(STATE), 0);
    chk({tag, "_pdn"},   int'(PLL_POWERDOWN_N), 0);
    chk({tag, "_rst"},   int'(RST_OUT), (1 << N) - 1);
    chk({tag, "_ready"}, int'(READY), 0);
    chk({tag, "_loss"},  int'(LOCK_LOSS_CNT), 0);
    chk({tag, "_retry"}, int'(RETRY_CNT), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lvl;
    int dur;

    // Reset state and nominal bring-up.
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check_reset_vals("reset");
    @(negedge CLK);
    RST = 1'b0;
    edges_until_pdn(1'b1, n);
    chk("pwrdn_len", n, PD);
    repeat (2) @(negedge CLK);
    PLL_LOCK = 1'b1;
    wait_until(1, 3'b110, 40, "nom_rst110");
    wait_until(1, 3'b100, G, "nom_rst100");
    wait_until(1, 3'b000, G, "nom_rst000");
    wait_until(2, 1, G, "nom_ready");
    chk("nom_state_run", int'(STATE), 3);

    // Lock loss in RUN, then relock.
    PLL_LOCK = 1'b0;
    repeat (S + 1) @(posedge CLK);
    #1;
    chk("loss_rst", int'(RST_OUT), 3'b111);
    chk("loss_ready", int'(READY), 0);
    chk("loss_cnt", int'(LOCK_LOSS_CNT), 1);
    chk("loss_state", int'(STATE), 1);
    chk("loss_pdn", int'(PLL_POWERDOWN_N), 1);
    @(negedge CLK);
    PLL_LOCK = 1'b1;
    wait_until(1, 3'b110, 40, "relock_rst110");
    wait_until(2, 1, 3 * G + 2, "relock_ready");

    // Software request during RELEASE, then coincident with a lock drop.
    do_reset();
    PLL_LOCK = 1'b1;
    wait_until(1, 3'b110, 60, "sw_rst110");
    SW_RESET_REQ = 1'b1;
    @(negedge CLK);
    SW_RESET_REQ = 1'b0;
    #1;
    chk("sw_state", int'(STATE), 0);
    chk("sw_rst", int'(RST_OUT), 3'b111);
    chk("sw_pdn", int'(PLL_POWERDOWN_N), 0);
    edges_until_pdn(1'b1, n);
    chk("sw_pwrdn_len", n, PD);
    wait_until(1, 3'b110, 60, "sw2_rst110");
    PLL_LOCK = 1'b0;
    repeat (2) @(negedge CLK);
    SW_RESET_REQ = 1'b1;
    @(negedge CLK);
    SW_RESET_REQ = 1'b0;
    #1;
    chk("swdrop_state", int'(STATE), 0);
    chk("swdrop_loss", int'(LOCK_LOSS_CNT), 1);

    // Glitchy lock restarts the stable count.
    do_reset();
    wait_until(3, 1, 20, "gl_pdn");
    PLL_LOCK = 1'b1;
    repeat (5) @(negedge CLK);
    PLL_LOCK = 1'b0;
    @(negedge CLK);
    PLL_LOCK = 1'b1;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (STATE !== 2'b10 && n < 100);
    chk("gl_release_delay", n, S + STB);
    chk("gl_retry", int'(RETRY_CNT), 0);

    // Asynchronous reset mid-RUN, with a lock loss counted beforehand.
    wait_until(2, 1, 20, "ar_ready");
    PLL_LOCK = 1'b0;
    repeat (5) @(negedge CLK);
    PLL_LOCK = 1'b1;
    wait_until(2, 1, 60, "ar_ready2");
    chk("ar_loss_before", int'(LOCK_LOSS_CNT), 1);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check_reset_vals("async");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // No lock: timeout, retry counting and saturation.
    PLL_LOCK = 1'b0;
    wait_until(3, 1, 20, "nl_pdn");
    edges_until_pdn(1'b0, n);
    chk("nl_wait_len", n, TO);
    chk("nl_retry1", int'(RETRY_CNT), 1);
    chk("nl_state", int'(STATE), 0);
    edges_until_pdn(1'b1, n);
    chk("nl_pwrdn_len", n, PD);
    repeat ((SAT + 4) * (TO + PD)) @(negedge CLK);
    #1;
    chk("nl_retry_sat", int'(RETRY_CNT), SAT);

    // Randomized lock behaviour with occasional software requests.
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      lvl = (seg % 2 == 0) ? 1 : 0;
      dur = lvl ? $urandom_range(5, 60) : $urandom_range(1, 8);
      for (int c = 0; c < dur; c++) begin
        PLL_LOCK = lvl[0];
        SW_RESET_REQ = ($urandom_range(0, 149) == 0);
        @(negedge CLK);
      end
    end
    SW_RESET_REQ = 1'b0;
    repeat (4) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
